tick_gen_multi: RTL and testbench

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

---
 rtl/tick_gen_pkg.sv | 9 +
 rtl/tick_gen_chan.sv | 68 ++++++
 rtl/tick_gen_multi.sv | 34 +++
 tb/tb_tick_gen_multi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen shared constants.
// Default counter width, channel count and reset terminal count.
package tick_gen_pkg;

  localparam int TG_WIDTH = 24;
  localparam int TG_NCH = 4;
  localparam logic [23:0] TG_DEF_PERIOD = 24'd6_000_000;

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: counter, active/shadow period, pend flag.
// Square-wave output exists only with TICK_GEN_WAVE_EN defined.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int WIDTH = TG_WIDTH,
  parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(TG_DEF_PERIOD)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             wave
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_p;
  logic [WIDTH-1:0] sh_p;
  logic             pend;
  logic             wrap;

  assign wrap = en && (cnt == act_p);

  // Counter and registered tick; disabled channels sit at zero.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + WIDTH'(1);
      tick <= wrap;
    end
  end

  // Period update: applied only at a wrap or while idle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      act_p <= DEF_PERIOD;
      sh_p  <= DEF_PERIOD;
      pend  <= 1'b0;
    end else if (load && (!en || wrap)) begin
      act_p <= period;
      pend  <= 1'b0;
    end else if (wrap && pend) begin
      act_p <= sh_p;
      pend  <= 1'b0;
    end else if (load) begin
      sh_p <= period;
      pend <= 1'b1;
    end
  end

`ifdef TICK_GEN_WAVE_EN
  // Toggle alongside each tick; holds while disabled.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) wave <= 1'b0;
    else if (wrap) wave <= ~wave;
  end
`else
  assign wave = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// NCH independent tick generators sharing one clock.
// Optional square-wave outputs via TICK_GEN_WAVE_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int WIDTH = TG_WIDTH,
  parameter int NCH = TG_NCH,
  parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(TG_DEF_PERIOD)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] period,
  input  logic [NCH-1:0]       load,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       wave
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_gen_chan #(
      .WIDTH(WIDTH),
      .DEF_PERIOD(DEF_PERIOD)
    ) u_chan (
      .clk_in(clk_in),
      .rst(rst),
      .en(en[i]),
      .load(load[i]),
      .period(period[i*WIDTH +: WIDTH]),
      .tick(tick[i]),
      .wave(wave[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi, WIDTH=8 NCH=2 DEF_PERIOD=3.
// Wave expectations follow TICK_GEN_WAVE_EN.
module tb_tick_gen_multi;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [15:0] period;
  logic [1:0]  load;
  logic [1:0]  tick;
  logic [1:0]  wave;

  int n_chk = 0;
  int n_fail = 0;

  tick_gen_multi #(
    .WIDTH(8),
    .NCH(2),
    .DEF_PERIOD(8'd3)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .period(period),
    .load(load),
    .tick(tick),
    .wave(wave)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic wx(input logic v);
`ifdef TICK_GEN_WAVE_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    load = '0;
    period = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = '0;
    load = '0;
    period = '0;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_wave", 32'(wave), 32'd0);

    // basic ticking, ch1 idle
    do_reset();
    en = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("s1_t0_e%0d", e), 32'(tick[0]), 32'(e % 4 == 0));
      check($sformatf("s1_t1_e%0d", e), 32'(tick[1]), 32'd0);
      check($sformatf("s1_w0_e%0d", e), 32'(wave[0]),
            32'(wx(1'((e / 4) % 2))));
    end

    // pending load at cnt=1 applies at current wrap
    do_reset();
    en = 2'b01;
    step();
    load = 2'b01;
    period = 16'h0001;
    step();
    load = 2'b00;
    check("s2_t0_e2", 32'(tick[0]), 32'd0);
    for (int e = 3; e <= 10; e++) begin
      step();
      check($sformatf("s2_t0_e%0d", e), 32'(tick[0]),
            32'(e >= 4 && e % 2 == 0));
    end

    // load in wrap cycle takes effect directly
    do_reset();
    en = 2'b01;
    for (int e = 1; e <= 3; e++) step();
    load = 2'b01;
    period = 16'h0005;
    for (int e = 4; e <= 16; e++) begin
      step();
      load = 2'b00;
      check($sformatf("s3_t0_e%0d", e), 32'(tick[0]),
            32'(e == 4 || e == 10 || e == 16));
    end

    // enable dropped mid-count
    do_reset();
    en = 2'b01;
    step();
    step();
    for (int e = 3; e <= 13; e++) begin
      en = (e >= 3 && e <= 5) ? 2'b00 : 2'b01;
      step();
      check($sformatf("s4_t0_e%0d", e), 32'(tick[0]),
            32'(e == 9 || e == 13));
    end

    // async reset drops pending load and outputs
    do_reset();
    en = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      if (e == 4) en = 2'b11;
      if (e == 6) begin
        load = 2'b01;
        period = 16'h0007;
      end
      step();
      load = 2'b00;
    end
    check("s5_pre_tick", 32'(tick), 32'd2);
    check("s5_pre_wave", 32'(wave), 32'(wx(1'b1)) * 32'd3);
    #2 rst = 1'b1;
    #1;
    check("s5_rst_tick", 32'(tick), 32'd0);
    check("s5_rst_wave", 32'(wave), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("s5_t_e%0d", e), 32'(tick),
            (e % 4 == 0) ? 32'd3 : 32'd0);
    end

    // zero period loaded while idle, ch1 runs alongside
    do_reset();
    load = 2'b01;
    period = 16'h0000;
    step();
    load = 2'b00;
    en = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("s6_t0_e%0d", e), 32'(tick[0]), 32'd1);
      check($sformatf("s6_t1_e%0d", e), 32'(tick[1]), 32'(e % 4 == 0));
      check($sformatf("s6_w0_e%0d", e), 32'(wave[0]),
            32'(wx(1'(e % 2))));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
